// File: rtl/map_hub_sw.sv
// Registered mapper-output selector: a programmable map_idx -> slot table picks one
// of NSLOT mapper buses, and slot changes pass through a drain/settle sequencer.
module map_hub_sw #(
    parameter int                NSLOT      = 8,
    parameter int                BW_OUT     = 64,
    parameter int                IDX_W      = 8,
    parameter int                SETTLE_CYC = 4,
    parameter logic [BW_OUT-1:0] SAFE_OUT   = '0,
    localparam int               SW         = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [IDX_W-1:0]        map_idx,
    input  logic [NSLOT*BW_OUT-1:0] map_in,
    input  logic                    bus_idle,
    input  logic                    tbl_we,
    input  logic [IDX_W-1:0]        tbl_addr,
    input  logic [SW:0]             tbl_data,
    output logic [BW_OUT-1:0]       map_out,
    output logic [SW-1:0]           cur_slot,
    output logic                    busy,
    output logic [7:0]              sw_cnt
);
    localparam int              TBL_N    = 1 << IDX_W;
    localparam int              CW       = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = (SETTLE_CYC > 0) ? CW'(SETTLE_CYC - 1) : '0;
    localparam logic [SW:0]     NSLOT_V  = (SW + 1)'(NSLOT);

    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_SETTLE = 2'd2} state_t;

    function automatic logic [SW-1:0] clamp_slot(input logic [SW-1:0] s);
        if ({1'b0, s} >= NSLOT_V) return '0;
        else                      return s;
    endfunction

    logic              r_tbl_v [TBL_N];
    logic [SW-1:0]     r_tbl_s [TBL_N];
    logic [SW-1:0]     r_tgt, r_cur, r_pend;
    logic [CW-1:0]     r_cnt;
    state_t            r_state;
    logic              r_busy;
    logic [7:0]        r_sw_cnt;
    logic [BW_OUT-1:0] r_out;

    logic [SW-1:0]     w_lookup;
    logic [BW_OUT-1:0] w_slot_bus [NSLOT];
    state_t            w_nxt_state;
    logic [SW-1:0]     w_nxt_cur, w_nxt_pend;
    logic [CW-1:0]     w_nxt_cnt;
    logic              w_nxt_busy, w_commit;
    logic [7:0]        w_nxt_sw_cnt;
    logic [BW_OUT-1:0] w_nxt_out;

    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        assign w_slot_bus[k] = map_in[k*BW_OUT +: BW_OUT];
    end

    // Table storage: writes land on the strobe edge, out-of-range slots fold to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TBL_N; i++) begin
                r_tbl_v[i] <= 1'b0;
                r_tbl_s[i] <= '0;
            end
        end else if (tbl_we) begin
            r_tbl_v[tbl_addr] <= tbl_data[SW];
            r_tbl_s[tbl_addr] <= clamp_slot(tbl_data[SW-1:0]);
        end
    end

    // Lookup forwards a same-cycle write so writes and index changes share one latency
    always_comb begin
        w_lookup = '0;
        if (tbl_we && (tbl_addr == map_idx)) begin
            w_lookup = tbl_data[SW] ? clamp_slot(tbl_data[SW-1:0]) : '0;
        end else if (r_tbl_v[map_idx]) begin
            w_lookup = r_tbl_s[map_idx];
        end else begin
            w_lookup = '0;
        end
    end

    // Switch sequencer next-state logic
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cur   = r_cur;
        w_nxt_pend  = r_pend;
        w_nxt_cnt   = r_cnt;
        w_nxt_busy  = r_busy;
        w_commit    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (r_tgt != r_cur) begin
                    w_nxt_state = ST_DRAIN;
                    w_nxt_pend  = r_tgt;
                    w_nxt_busy  = 1'b1;
                end else begin
                    w_nxt_busy  = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (r_tgt == r_cur) begin
                    w_nxt_state = ST_RUN;
                    w_nxt_busy  = 1'b0;
                end else if (bus_idle) begin
                    if (SETTLE_CYC > 0) begin
                        w_nxt_state = ST_SETTLE;
                        w_nxt_cnt   = CNT_LOAD;
                        w_nxt_pend  = r_tgt;
                    end else begin
                        w_commit    = 1'b1;
                        w_nxt_cur   = r_tgt;
                        w_nxt_state = ST_RUN;
                        w_nxt_busy  = 1'b0;
                    end
                end else begin
                    w_nxt_pend  = r_tgt;
                end
            end
            ST_SETTLE: begin
                if (r_tgt == r_cur) begin
                    w_nxt_state = ST_RUN;
                    w_nxt_busy  = 1'b0;
                end else if (r_tgt != r_pend) begin
                    w_nxt_pend  = r_tgt;
                    w_nxt_cnt   = CNT_LOAD;
                end else if (r_cnt == '0) begin
                    w_commit    = 1'b1;
                    w_nxt_cur   = r_pend;
                    w_nxt_state = ST_RUN;
                    w_nxt_busy  = 1'b0;
                end else begin
                    w_nxt_cnt   = r_cnt - CW'(1);
                end
            end
            default: begin
                w_nxt_state = ST_RUN;
                w_nxt_busy  = 1'b0;
            end
        endcase
        w_nxt_sw_cnt = (w_commit && (r_sw_cnt != 8'hFF)) ? (r_sw_cnt + 8'd1) : r_sw_cnt;
        w_nxt_out    = (r_state == ST_RUN) ? w_slot_bus[r_cur] : SAFE_OUT;
    end

    // State, lookup and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_tgt    <= '0;
            r_cur    <= '0;
            r_pend   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_sw_cnt <= 8'd0;
            r_out    <= SAFE_OUT;
        end else begin
            r_state  <= w_nxt_state;
            r_tgt    <= w_lookup;
            r_cur    <= w_nxt_cur;
            r_pend   <= w_nxt_pend;
            r_cnt    <= w_nxt_cnt;
            r_busy   <= w_nxt_busy;
            r_sw_cnt <= w_nxt_sw_cnt;
            r_out    <= w_nxt_out;
        end
    end

    assign map_out  = r_out;
    assign cur_slot = r_cur;
    assign busy     = r_busy;
    assign sw_cnt   = r_sw_cnt;
endmodule
